// File: rtl/huffman_pkg.sv
// rtl/huffman_pkg.sv - shared constants, symbol order tables and FSM state type for the Huffman code sequencer
package huffman_pkg;

  localparam int NSYM    = 8;
  localparam int MAXLEN  = 7;
  localparam int LENW    = 3;
  localparam int SEQ_LEN = 5;

  localparam int SYM_W = $clog2(NSYM);
  localparam int POS_W = $clog2(SEQ_LEN);
  localparam int BIT_W = $clog2(MAXLEN);

  typedef logic [SYM_W-1:0] sym_t;

  localparam sym_t SYM_A = 3'd0;
  localparam sym_t SYM_B = 3'd1;
  localparam sym_t SYM_C = 3'd2;
  localparam sym_t SYM_E = 3'd3;
  localparam sym_t SYM_I = 3'd4;
  localparam sym_t SYM_L = 3'd5;
  localparam sym_t SYM_O = 3'd6;
  localparam sym_t SYM_V = 3'd7;

  // Word position p lives at [p*SYM_W +: SYM_W]; position 0 is the first symbol sent.
  localparam logic [SEQ_LEN*SYM_W-1:0] ORDER_ILOVE = {SYM_E, SYM_V, SYM_O, SYM_L, SYM_I};
  localparam logic [SEQ_LEN*SYM_W-1:0] ORDER_ICLAB = {SYM_B, SYM_A, SYM_L, SYM_C, SYM_I};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_FIN
  } state_t;

  function automatic logic [LENW-1:0] clamp_len(input logic [LENW-1:0] len);
    return (int'(len) > MAXLEN) ? LENW'(MAXLEN) : len;
  endfunction

endpackage

// File: rtl/huffman_code_sequencer_if.sv
// rtl/huffman_code_sequencer_if.sv - table/start inputs and serial code outputs of the code sequencer
interface huffman_code_sequencer_if;
  import huffman_pkg::*;

  logic                   start;
  logic                   mode;
  logic [NSYM*MAXLEN-1:0] code_flat;
  logic [NSYM*LENW-1:0]   len_flat;
  logic                   busy;
  logic                   out_valid;
  logic                   out_code;
  logic                   done;

  modport master (
    output start, mode, code_flat, len_flat,
    input  busy, out_valid, out_code, done
  );

  modport slave (
    input  start, mode, code_flat, len_flat,
    output busy, out_valid, out_code, done
  );

endinterface

// File: rtl/huffman_order_rom.sv
// rtl/huffman_order_rom.sv - maps (mode, word position) to the symbol index sent at that position
module huffman_order_rom
  import huffman_pkg::*;
(
  input  logic             mode_i,
  input  logic [POS_W-1:0] pos_i,
  output sym_t             sym_o
);

  always_comb begin
    sym_o = SYM_I;
    if (int'(pos_i) < SEQ_LEN) begin
      sym_o = mode_i ? ORDER_ICLAB[int'(pos_i)*SYM_W +: SYM_W]
                     : ORDER_ILOVE[int'(pos_i)*SYM_W +: SYM_W];
    end
  end

endmodule

// File: rtl/huffman_code_sequencer.sv
// rtl/huffman_code_sequencer.sv - latches the code table on start and serialises the selected word's codes MSB first
module huffman_code_sequencer
  import huffman_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  huffman_code_sequencer_if.slave bus
);

  state_t            state_q, state_d;
  logic              mode_q;
  logic [MAXLEN-1:0] code_q [NSYM];
  logic [LENW-1:0]   len_q  [NSYM];
  logic [POS_W-1:0]  sym_idx_q, sym_idx_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic              out_code_q, out_code_d;
  logic              done_q, done_d;
  logic              latch_en;

  sym_t              order_sym [SEQ_LEN];
  logic [SEQ_LEN-1:0] nz;
  logic              first_found, next_found;
  logic [POS_W-1:0]  first_pos, next_pos;
  sym_t              cur_sym;

  for (genvar p = 0; p < SEQ_LEN; p++) begin : g_order
    huffman_order_rom u_order_rom (
      .mode_i (mode_q),
      .pos_i  (POS_W'(p)),
      .sym_o  (order_sym[p])
    );
  end

  always_comb begin
    nz = '0;
    for (int p = 0; p < SEQ_LEN; p++) begin
      nz[p] = |len_q[order_sym[p]];
    end
  end

  assign cur_sym = order_sym[sym_idx_q];

  // Lowest non-empty position overall (for LOAD) and strictly after the current one (for SEND).
  always_comb begin
    first_found = 1'b0;
    first_pos   = '0;
    next_found  = 1'b0;
    next_pos    = '0;
    for (int p = SEQ_LEN - 1; p >= 0; p--) begin
      if (nz[p]) begin
        first_found = 1'b1;
        first_pos   = POS_W'(p);
      end
      if (nz[p] && (p > int'(sym_idx_q))) begin
        next_found = 1'b1;
        next_pos   = POS_W'(p);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sym_idx_d   = sym_idx_q;
    bit_idx_d   = bit_idx_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    out_code_d  = 1'b0;
    done_d      = 1'b0;
    latch_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        // done_q still high means FIN just ended; a start in that cycle is dropped.
        if (bus.start && !done_q) begin
          latch_en = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sym_idx_d = first_pos;
        bit_idx_d = BIT_W'(len_q[order_sym[first_pos]] - 1'b1);
        state_d   = first_found ? ST_SEND : ST_FIN;
      end
      ST_SEND: begin
        out_valid_d = 1'b1;
        out_code_d  = code_q[cur_sym][bit_idx_q];
        if (bit_idx_q == '0) begin
          if (next_found) begin
            sym_idx_d = next_pos;
            bit_idx_d = BIT_W'(len_q[order_sym[next_pos]] - 1'b1);
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          bit_idx_d = bit_idx_q - 1'b1;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sym_idx_q   <= '0;
      bit_idx_q   <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_idx_q   <= sym_idx_d;
      bit_idx_q   <= bit_idx_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      for (int s = 0; s < NSYM; s++) begin
        code_q[s] <= '0;
        len_q[s]  <= '0;
      end
    end else if (latch_en) begin
      mode_q <= bus.mode;
      for (int s = 0; s < NSYM; s++) begin
        code_q[s] <= bus.code_flat[s*MAXLEN +: MAXLEN];
        len_q[s]  <= clamp_len(bus.len_flat[s*LENW +: LENW]);
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_huffman_code_sequencer.sv
// tb/tb_huffman_code_sequencer.sv - directed and random-table bench for huffman_code_sequencer
module tb_huffman_code_sequencer;
  import huffman_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  huffman_code_sequencer_if bus ();

  huffman_code_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [55:0] pack_codes(input logic [6:0] a, b, c, e, i, l, o, v);
    return {v, o, l, i, e, c, b, a};
  endfunction

  function automatic logic [23:0] pack_lens(input logic [2:0] a, b, c, e, i, l, o, v);
    return {v, o, l, i, e, c, b, a};
  endfunction

  function automatic void model(input logic m, input logic [55:0] codes, input logic [23:0] lens,
                                output logic [63:0] bits, output int n);
    int ord [5];
    int s;
    int len;
    if (m) ord = '{4, 2, 5, 0, 1};
    else   ord = '{4, 5, 6, 7, 3};
    bits = '0;
    n    = 0;
    for (int p = 0; p < 5; p++) begin
      s   = ord[p];
      len = int'(lens[s*3 +: 3]);
      for (int b = len - 1; b >= 0; b--) begin
        bits = {bits[62:0], codes[s*7 + b]};
        n++;
      end
    end
  endfunction

  // Pulses start, then samples every cycle until one cycle past the first done.
  // poke bit k raises start for the cycle following sample k.
  task automatic run_word(input logic m, input logic [55:0] codes, input logic [23:0] lens,
                          input logic [63:0] poke,
                          output logic [63:0] bits, output int nbits, output int first_v,
                          output int done_at, output int busy_cnt, output int done_cnt,
                          output bit zero_bad, output bit gap);
    int last_v;
    int stop_k;
    bus.mode      = m;
    bus.code_flat = codes;
    bus.len_flat  = lens;
    bus.start     = 1'b1;
    bits = '0; nbits = 0; first_v = -1; done_at = -1; busy_cnt = 0; done_cnt = 0;
    zero_bad = 1'b0; gap = 1'b0; last_v = -1; stop_k = 100;
    tick();
    for (int k = 0; k <= stop_k; k++) begin
      if (k > 0) tick();
      bus.start = (k < 64) ? poke[k] : 1'b0;
      if (bus.out_valid) begin
        bits = {bits[62:0], bus.out_code};
        nbits++;
        if (first_v < 0) first_v = k;
        else if (last_v != k - 1) gap = 1'b1;
        last_v = k;
      end else if (bus.out_code) begin
        zero_bad = 1'b1;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          stop_k  = k + 1;
        end
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic verify(input string tag, input logic m, input logic [55:0] codes,
                        input logic [23:0] lens, input logic [63:0] poke,
                        input logic [63:0] exp_bits, input int exp_n);
    logic [63:0] bits;
    int nbits, first_v, done_at, busy_cnt, done_cnt;
    bit zero_bad, gap;
    run_word(m, codes, lens, poke, bits, nbits, first_v, done_at, busy_cnt, done_cnt, zero_bad, gap);
    check({tag, "_bits"},    bits,     exp_bits);
    check({tag, "_nbits"},   nbits,    exp_n);
    check({tag, "_first_v"}, first_v,  (exp_n > 0) ? 2 : -1);
    check({tag, "_done_at"}, done_at,  exp_n + 2);
    check({tag, "_busy"},    busy_cnt, exp_n + 2);
    check({tag, "_ndone"},   done_cnt, 1);
    check({tag, "_zero"},    zero_bad, 1'b0);
    check({tag, "_gap"},     gap,      1'b0);
  endtask

  initial begin
    logic [55:0] c1, c2, cr;
    logic [23:0] l1, l2, l3, l4, lr;
    logic [63:0] eb;
    int          en;
    logic        mr;

    c1 = pack_codes(7'h55, 7'h2A, 7'h11, 7'b1100010, 7'b1111110, 7'b0101011, 7'b1111000, 7'b0000001);
    l1 = pack_lens(3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd3, 3'd3);
    c2 = pack_codes(7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7);
    l2 = pack_lens(3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3);
    l3 = pack_lens(3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd0, 3'd3, 3'd3);
    l4 = pack_lens(3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.mode      = 1'b0;
    bus.code_flat = '0;
    bus.len_flat  = '0;
    tick();
    tick();
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_code",  bus.out_code,  1'b0);
    check("rst_busy",  bus.busy,      1'b0);
    check("rst_done",  bus.done,      1'b0);
    rst = 1'b0;
    tick();

    verify("ilove",  1'b0, c1, l1, 64'd0, 64'b1011000001010, 13);
    verify("iclab",  1'b1, c2, l2, 64'd0, 64'b100010101000001, 15);
    verify("skip_l", 1'b0, c1, l3, 64'd0, 64'b10000001010, 11);
    verify("empty",  1'b0, c1, l4, 64'd0, 64'd0, 0);
    verify("poke",   1'b0, c1, l1, (64'd1 << 4) | (64'd1 << 14) | (64'd1 << 15), 64'b1011000001010, 13);

    bus.mode      = 1'b1;
    bus.code_flat = c2;
    bus.len_flat  = l2;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("mid_valid", bus.out_valid, 1'b1);
    check("mid_code",  bus.out_code,  1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_code",  bus.out_code,  1'b0);
    check("arst_busy",  bus.busy,      1'b0);
    check("arst_done",  bus.done,      1'b0);
    #3 rst = 1'b0;
    tick();
    tick();
    check("post_rst_busy",  bus.busy,      1'b0);
    check("post_rst_valid", bus.out_valid, 1'b0);
    verify("after_rst", 1'b1, c2, l2, 64'd0, 64'b100010101000001, 15);

    for (int i = 0; i < 4; i++) begin
      cr = {$urandom, $urandom};
      lr = 24'($urandom);
      mr = 1'($urandom_range(0, 1));
      model(mr, cr, lr, eb, en);
      verify($sformatf("rnd%0d", i), mr, cr, lr, 64'd0, eb, en);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
